vigna_bus_arb: RTL and testbench

- Two-master, one-slave arbiter directly downstream of the vigna core. It merges the core's instruction bus (i_*) and data bus (d_*) onto one unified memory bus (m_*).
- Uses the same valid/ready handshake the core drives, with round-robin tie-breaking.
- Includes a per-transaction timeout watchdog, so a dead slave cannot hang the core.

---
 rtl/vigna_bus_arb_if.sv | 13 +
 rtl/vigna_bus_arb.sv | 131 +++++++++++++
 tb/tb_vigna_bus_arb.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vigna_bus_arb_if.sv
// Unified vigna memory bus: valid/ready request with address, write payload and read data.
// The master side raises valid with a stable payload; the slave side pulses ready, with rdata valid in that cycle.
interface vigna_bus_arb_if;
  logic        valid;
  logic        ready;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic [31:0] wdata;
  logic [3:0]  wstrb;

  modport master (output valid, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/vigna_bus_arb.sv
// Round-robin merge of the vigna instruction and data buses onto one memory bus, with a timeout watchdog.
// Grant 1 cycle after the request; payload and ready/rdata pass through combinationally while granted.
module vigna_bus_arb #(
  parameter int unsigned TIMEOUT  = 256,
  parameter logic [31:0] TO_RDATA = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            resetn,
  vigna_bus_arb_if.slave  i_bus,
  vigna_bus_arb_if.slave  d_bus,
  vigna_bus_arb_if.master m_bus,
  output logic            to_err,
  output logic [31:0]     to_addr
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          last_d, last_d_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          to_err_nxt;
  logic [31:0]   to_addr_nxt;

  logic          granted;
  logic          wdog_hit;
  logic          expire;
  logic          done;
  logic [31:0]   rsel;
  logic [31:0]   gnt_addr;

  // The instruction side is always issued as a read, so its write payload is dropped.
  logic          i_unused;
  assign i_unused = ^{i_bus.wdata, i_bus.wstrb};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      last_d  <= 1'b0;
      cnt     <= '0;
      to_err  <= 1'b0;
      to_addr <= 32'h0;
    end else begin
      state   <= state_nxt;
      last_d  <= last_d_nxt;
      cnt     <= cnt_nxt;
      to_err  <= to_err_nxt;
      to_addr <= to_addr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    last_d_nxt  = last_d;
    cnt_nxt     = cnt;
    to_err_nxt  = to_err;
    to_addr_nxt = to_addr;
    gnt_addr    = 32'h0;

    m_bus.valid = 1'b0;
    m_bus.addr  = 32'h0;
    m_bus.wdata = 32'h0;
    m_bus.wstrb = 4'h0;
    i_bus.ready = 1'b0;
    i_bus.rdata = 32'h0;
    d_bus.ready = 1'b0;
    d_bus.rdata = 32'h0;

    granted  = (state == GNT_I) || (state == GNT_D);
    wdog_hit = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));
    // A real m_ready in the expiry cycle wins over the watchdog.
    expire   = granted && !m_bus.ready && wdog_hit;
    done     = granted && (m_bus.ready || expire);
    rsel     = expire ? TO_RDATA : m_bus.rdata;

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (i_bus.valid && d_bus.valid) begin
          state_nxt = last_d ? GNT_I : GNT_D;
        end else if (d_bus.valid) begin
          state_nxt = GNT_D;
        end else if (i_bus.valid) begin
          state_nxt = GNT_I;
        end
      end
      GNT_I: begin
        gnt_addr    = i_bus.addr;
        m_bus.valid = 1'b1;
        m_bus.addr  = i_bus.addr;
        i_bus.ready = done;
        i_bus.rdata = rsel;
      end
      GNT_D: begin
        gnt_addr    = d_bus.addr;
        m_bus.valid = 1'b1;
        m_bus.addr  = d_bus.addr;
        m_bus.wdata = d_bus.wdata;
        m_bus.wstrb = d_bus.wstrb;
        d_bus.ready = done;
        d_bus.rdata = rsel;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (granted) begin
      if (done) begin
        state_nxt  = IDLE;
        cnt_nxt    = '0;
        last_d_nxt = (state == GNT_D);
      end else if ((TIMEOUT != 0) && (cnt != '1)) begin
        cnt_nxt = cnt + 1'b1;
      end
      // Only the first timeout address is kept; the flag itself is sticky.
      if (expire) begin
        to_err_nxt = 1'b1;
        if (!to_err) begin
          to_addr_nxt = gnt_addr;
        end
      end
    end
  end

endmodule

// File: tb/tb_vigna_bus_arb.sv
// Bench for vigna_bus_arb: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a transaction-level model of the arbiter.
module tb_vigna_bus_arb;
  localparam int          TO  = 8;
  localparam logic [31:0] TOR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        to_err;
  logic [31:0] to_addr;

  int checks = 0;
  int errors = 0;

  vigna_bus_arb_if i_bus ();
  vigna_bus_arb_if d_bus ();
  vigna_bus_arb_if m_bus ();

  vigna_bus_arb #(.TIMEOUT(TO), .TO_RDATA(TOR)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .i_bus   (i_bus),
    .d_bus   (d_bus),
    .m_bus   (m_bus),
    .to_err  (to_err),
    .to_addr (to_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave behaviour: fixed latency when fix_lat >= 0, otherwise random per transaction.
  int          fix_lat = 0;
  logic [31:0] fix_data = 32'h0;

  initial begin
    int lat, wcnt;
    bit in_txn;
    lat = 0; wcnt = 0; in_txn = 0;
    m_bus.ready = 1'b0;
    m_bus.rdata = 32'h0;
    forever begin
      @(posedge clk); #2;
      if (!resetn || !m_bus.valid) begin
        in_txn = 0;
        m_bus.ready = 1'b0;
        m_bus.rdata = $urandom;
      end else begin
        if (!in_txn) begin
          in_txn = 1;
          wcnt = 0;
          if (fix_lat >= 0) lat = fix_lat;
          else if ($urandom_range(0, 3) == 0) lat = $urandom_range(6, 9);
          else lat = $urandom_range(0, 2);
        end else begin
          wcnt++;
        end
        m_bus.ready = (wcnt == lat);
        m_bus.rdata = (m_bus.ready && fix_lat >= 0) ? fix_data : $urandom;
      end
    end
  end

  // Model: who owns the bus (0 none, 1 I, 2 D), how long it has waited, who won last.
  int          own = 0;
  int          age = 0;
  bit          last_d = 0;
  bit          merr = 0;
  logic [31:0] maddr = 32'h0;
  bit          prev_mv = 0;

  int          done_q[$];
  logic [31:0] rdat_q[$];
  logic [31:0] st_addr_q[$];
  logic [31:0] st_wdata_q[$];
  logic [3:0]  st_wstrb_q[$];

  always @(negedge clk) begin
    logic [31:0] a, wd, rd;
    logic [3:0]  ws;
    bit          mv, expire, done;
    if (!resetn) begin
      own = 0; age = 0; last_d = 0; merr = 0; maddr = 32'h0; prev_mv = 0;
      chk("rst_m_valid", {31'd0, m_bus.valid}, 32'd0);
      chk("rst_i_ready", {31'd0, i_bus.ready}, 32'd0);
      chk("rst_d_ready", {31'd0, d_bus.ready}, 32'd0);
      chk("rst_to_err",  {31'd0, to_err}, 32'd0);
      chk("rst_to_addr", to_addr, 32'd0);
      chk("rst_m_addr",  m_bus.addr, 32'd0);
    end else begin
      mv     = (own != 0);
      a      = (own == 1) ? i_bus.addr : (own == 2) ? d_bus.addr : 32'h0;
      wd     = (own == 2) ? d_bus.wdata : 32'h0;
      ws     = (own == 2) ? d_bus.wstrb : 4'h0;
      expire = mv && !m_bus.ready && (age == TO - 1);
      done   = mv && (m_bus.ready || expire);
      rd     = expire ? TOR : m_bus.rdata;

      chk("m_valid", {31'd0, m_bus.valid}, {31'd0, mv});
      chk("m_addr",  m_bus.addr, a);
      chk("m_wdata", m_bus.wdata, wd);
      chk("m_wstrb", {28'd0, m_bus.wstrb}, {28'd0, ws});
      chk("i_ready", {31'd0, i_bus.ready}, {31'd0, done && own == 1});
      chk("d_ready", {31'd0, d_bus.ready}, {31'd0, done && own == 2});
      if (own != 1)  chk("i_rdata_idle", i_bus.rdata, 32'h0);
      else if (done) chk("i_rdata", i_bus.rdata, rd);
      if (own != 2)  chk("d_rdata_idle", d_bus.rdata, 32'h0);
      else if (done) chk("d_rdata", d_bus.rdata, rd);
      chk("to_err",  {31'd0, to_err}, {31'd0, merr});
      chk("to_addr", to_addr, maddr);

      if (m_bus.valid && !prev_mv) begin
        st_addr_q.push_back(m_bus.addr);
        st_wdata_q.push_back(m_bus.wdata);
        st_wstrb_q.push_back(m_bus.wstrb);
      end
      prev_mv = m_bus.valid;
      if (i_bus.ready) begin done_q.push_back(0); rdat_q.push_back(i_bus.rdata); end
      if (d_bus.ready) begin done_q.push_back(1); rdat_q.push_back(d_bus.rdata); end

      if (own == 0) begin
        age = 0;
        if (i_bus.valid && d_bus.valid) own = last_d ? 1 : 2;
        else if (d_bus.valid)           own = 2;
        else if (i_bus.valid)           own = 1;
      end else if (done) begin
        if (expire) begin
          if (!merr) maddr = a;
          merr = 1;
        end
        last_d = (own == 2);
        own = 0;
      end else begin
        age++;
      end
    end
  end

  // Raise the selected requests together and serve them to completion; mvc counts m_valid cycles.
  task automatic run_reqs(input bit iv, input bit dv, input logic [31:0] ia, input logic [31:0] da,
                          input logic [31:0] dw, input logic [3:0] ds, output int mvc);
    bit ip, dp, ir, dr;
    int n;
    done_q.delete(); rdat_q.delete();
    st_addr_q.delete(); st_wdata_q.delete(); st_wstrb_q.delete();
    @(posedge clk); #1;
    i_bus.valid = iv; i_bus.addr = ia; i_bus.wdata = $urandom; i_bus.wstrb = 4'hF;
    d_bus.valid = dv; d_bus.addr = da; d_bus.wdata = dw; d_bus.wstrb = ds;
    ip = iv; dp = dv; n = 0; mvc = 0;
    while ((ip || dp) && n < 100) begin
      @(negedge clk);
      ir = i_bus.ready; dr = d_bus.ready;
      if (m_bus.valid) mvc++;
      @(posedge clk); #1;
      if (ir) begin i_bus.valid = 1'b0; ip = 0; end
      if (dr) begin d_bus.valid = 1'b0; dp = 0; end
      n++;
    end
    chk("reqs_completed", {31'd0, ip || dp}, 32'd0);
  endtask

  initial begin
    int mvc, n;
    int ord[$];
    bit ir, dr;
    i_bus.valid = 1'b0; i_bus.addr = 32'h0; i_bus.wdata = 32'h0; i_bus.wstrb = 4'h0;
    d_bus.valid = 1'b0; d_bus.addr = 32'h0; d_bus.wdata = 32'h0; d_bus.wstrb = 4'h0;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    // Simultaneous requests straight after reset: D wins, then I after one idle cycle.
    fix_lat = 0;
    run_reqs(1, 1, 32'h4, 32'h2000, 32'hDEAD_BEEF, 4'hF, mvc);
    chk("tie_count", done_q.size(), 2);
    if (done_q.size() == 2 && st_addr_q.size() == 2) begin
      chk("tie_first_is_d", done_q[0], 1);
      chk("tie_second_is_i", done_q[1], 0);
      chk("tie_d_addr", st_addr_q[0], 32'h2000);
      chk("tie_d_wdata", st_wdata_q[0], 32'hDEAD_BEEF);
      chk("tie_d_wstrb", {28'd0, st_wstrb_q[0]}, 32'hF);
      chk("tie_i_addr", st_addr_q[1], 32'h4);
      chk("tie_i_wstrb", {28'd0, st_wstrb_q[1]}, 32'h0);
      chk("tie_i_wdata", st_wdata_q[1], 32'h0);
    end

    // Lone fetch with a one-wait slave.
    fix_lat = 1; fix_data = 32'h0000_0013;
    run_reqs(1, 0, 32'h100, 32'h0, 32'h0, 4'h0, mvc);
    chk("fetch_count", done_q.size(), 1);
    if (done_q.size() == 1) begin
      chk("fetch_is_i", done_q[0], 0);
      chk("fetch_rdata", rdat_q[0], 32'h13);
      chk("fetch_addr", st_addr_q[0], 32'h100);
      chk("fetch_wstrb", {28'd0, st_wstrb_q[0]}, 32'h0);
    end
    chk("fetch_mv_cycles", mvc, 2);

    // Two rounds of ties: D, I, D, I.
    fix_lat = 0;
    ord.delete();
    repeat (2) begin
      run_reqs(1, 1, 32'h10, 32'h20, 32'h1234_5678, 4'h3, mvc);
      foreach (done_q[k]) ord.push_back(done_q[k]);
    end
    chk("rr_count", ord.size(), 4);
    if (ord.size() == 4) begin
      chk("rr_0", ord[0], 1);
      chk("rr_1", ord[1], 0);
      chk("rr_2", ord[2], 1);
      chk("rr_3", ord[3], 0);
    end

    // After a lone D, the next tie goes to I.
    run_reqs(0, 1, 32'h0, 32'h2100, 32'h0, 4'h0, mvc);
    run_reqs(1, 1, 32'h30, 32'h2200, 32'h0, 4'h0, mvc);
    if (done_q.size() == 2) chk("rr_after_d", done_q[0], 0);
    else chk("rr_after_d_count", done_q.size(), 2);

    // m_ready in the expiry cycle is a normal completion.
    fix_lat = 7; fix_data = 32'h55;
    run_reqs(0, 1, 32'h0, 32'h3004, 32'h0, 4'h0, mvc);
    chk("edge_mv_cycles", mvc, 8);
    if (rdat_q.size() == 1) chk("edge_rdata", rdat_q[0], 32'h55);
    else chk("edge_count", rdat_q.size(), 1);
    chk("edge_no_err", {31'd0, to_err}, 32'd0);

    // Silent slave: forced completion, sticky error, first address kept.
    fix_lat = 100;
    run_reqs(0, 1, 32'h0, 32'h3000, 32'h0, 4'h0, mvc);
    chk("to_mv_cycles", mvc, 8);
    if (rdat_q.size() == 1) chk("to_rdata", rdat_q[0], 32'h0);
    else chk("to_count", rdat_q.size(), 1);
    chk("to_err_set", {31'd0, to_err}, 32'd1);
    chk("to_addr_first", to_addr, 32'h3000);
    run_reqs(1, 0, 32'h5000, 32'h0, 32'h0, 4'h0, mvc);
    chk("to2_mv_cycles", mvc, 8);
    chk("to2_addr_kept", to_addr, 32'h3000);

    // Random traffic against the model.
    fix_lat = -1;
    repeat (3000) begin
      @(negedge clk);
      ir = i_bus.ready; dr = d_bus.ready;
      @(posedge clk); #1;
      if (ir) i_bus.valid = 1'b0;
      else if (!i_bus.valid && $urandom_range(0, 3) != 0) begin
        i_bus.valid = 1'b1; i_bus.addr = $urandom; i_bus.wdata = $urandom; i_bus.wstrb = 4'($urandom);
      end
      if (dr) d_bus.valid = 1'b0;
      else if (!d_bus.valid && $urandom_range(0, 3) != 0) begin
        d_bus.valid = 1'b1; d_bus.addr = $urandom; d_bus.wdata = $urandom;
        d_bus.wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      end
    end
    n = 0;
    while ((i_bus.valid || d_bus.valid) && n < 100) begin
      @(negedge clk);
      ir = i_bus.ready; dr = d_bus.ready;
      @(posedge clk); #1;
      if (ir) i_bus.valid = 1'b0;
      if (dr) d_bus.valid = 1'b0;
      n++;
    end
    chk("drain_done", {30'd0, i_bus.valid, d_bus.valid}, 32'd0);

    // Async reset in the middle of a D grant.
    fix_lat = 100;
    @(posedge clk); #1;
    d_bus.valid = 1'b1; d_bus.addr = 32'h6000; d_bus.wstrb = 4'h0;
    repeat (3) @(posedge clk);
    #2 chk("pre_rst_m_valid", {31'd0, m_bus.valid}, 32'd1);
    #1 resetn = 1'b0; d_bus.valid = 1'b0;
    #1;
    chk("arst_m_valid", {31'd0, m_bus.valid}, 32'd0);
    chk("arst_d_ready", {31'd0, d_bus.ready}, 32'd0);
    chk("arst_to_err", {31'd0, to_err}, 32'd0);
    chk("arst_to_addr", to_addr, 32'd0);
    @(posedge clk); #1 resetn = 1'b1;
    fix_lat = 0;
    run_reqs(1, 1, 32'h40, 32'h7000, 32'h0, 4'h0, mvc);
    if (done_q.size() == 2) chk("arst_tie_d_first", done_q[0], 1);
    else chk("arst_tie_count", done_q.size(), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
